// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC generator and its branch target buffer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Instruction progMem substitutes while a flush is asserted (addi x0,x0,0).
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Byte distance between consecutive sequential fetches.
  localparam int PC_STEP = 4;

  // One BTB line; tag and target hold only in-range address bits, the rest stay zero.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
  } btb_entry_t;

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// write on the clock edge after bt_update. A write and a lookup of the same
// index in the same cycle return the entry as it was before the write.
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int MEM_BYTES   = 256,
  parameter int BTB_ENTRIES = 4
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [31:0] pc,
  output logic        hit,
  output logic [31:0] hit_target,
  input  logic        bt_update,
  input  logic [31:0] bt_pc,
  input  logic [31:0] bt_target
);

  localparam int          IW        = $clog2(BTB_ENTRIES);
  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  btb_entry_t    btb_q [BTB_ENTRIES];
  btb_entry_t    wr_entry;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic [31:0]   rd_tag;

  assign rd_idx = pc[2 +: IW];
  assign wr_idx = bt_pc[2 +: IW];
  assign rd_tag = (pc & ADDR_MASK) >> (2 + IW);

  // Look up the current fetch PC and assemble the line a pending update would write.
  always_comb begin
    hit             = btb_q[rd_idx].valid && (btb_q[rd_idx].tag == rd_tag);
    hit_target      = btb_q[rd_idx].target;
    wr_entry.valid  = 1'b1;
    wr_entry.tag    = (bt_pc & ADDR_MASK) >> (2 + IW);
    wr_entry.target = bt_target & ADDR_MASK;
  end

  // Clear every line on reset; otherwise install the resolved taken branch.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i] <= '0;
      end
    end else if (bt_update) begin
      btb_q[wr_idx] <= wr_entry;
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: owns the architectural fetch PC, picks the next PC
// (redirect > hold > BTB hit > PC+4), flushes progMem and tracks the PC,
// validity and prediction of the instruction progMem is presenting.
// Define FETCH_BTB_EN to build in the branch target buffer.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          MEM_BYTES    = 256,
  parameter int          BTB_ENTRIES  = 4
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        hold,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        bt_update,
  input  logic [31:0] bt_pc,
  input  logic [31:0] bt_target,
  output logic [31:0] PC,
  output logic        flush_fetch,
  output logic [31:0] PC_ID,
  output logic        valid_ID,
  output logic        pred_taken_ID,
  output logic        misalign_trap,
  output logic [31:0] trap_pc
);

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  fetch_state_e state;
  fetch_state_e state_next;
  logic [31:0]  pc_q;
  logic [31:0]  pc_next;
  logic [31:0]  pc_id_q;
  logic         pc_id_load;
  logic         valid_q;
  logic         valid_next;
  logic         pred_q;
  logic         pred_next;
  logic         trap_q;
  logic         trap_next;
  logic [31:0]  trap_pc_q;
  logic         btb_hit;
  logic [31:0]  btb_target;

`ifdef FETCH_BTB_EN
  fetch_btb #(
    .MEM_BYTES  (MEM_BYTES),
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .Clock     (Clock),
    .nReset    (nReset),
    .pc        (pc_q),
    .hit       (btb_hit),
    .hit_target(btb_target),
    .bt_update (bt_update),
    .bt_pc     (bt_pc),
    .bt_target (bt_target)
  );
`else
  logic unused_bt;
  assign unused_bt  = ^{bt_update, bt_pc, bt_target};
  assign btb_hit    = 1'b0;
  assign btb_target = '0;
`endif

  // Next state, next PC and the qualifiers of the instruction fetched this cycle.
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    pc_id_load = 1'b0;
    valid_next = 1'b0;
    pred_next  = 1'b0;
    trap_next  = 1'b0;
    case (state)
      BOOT, RUN: begin
        state_next = RUN;
        if (redirect) begin
          pc_id_load = 1'b1;
          if (redirect_target[1:0] != 2'b00) begin
            trap_next  = 1'b1;
            state_next = HALT;
          end else begin
            pc_next = redirect_target & ADDR_MASK;
          end
        end else if (!hold) begin
          pc_id_load = 1'b1;
          valid_next = 1'b1;
          if (btb_hit) begin
            pc_next   = btb_target & ADDR_MASK;
            pred_next = 1'b1;
          end else begin
            pc_next = (pc_q + 32'(PC_STEP)) & ADDR_MASK;
          end
        end
      end
      HALT: state_next = HALT;
      default: state_next = HALT;
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Fetch PC, ID-stage tracking and trap capture registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pc_q      <= RESET_VECTOR & ADDR_MASK;
      pc_id_q   <= RESET_VECTOR & ADDR_MASK;
      valid_q   <= 1'b0;
      pred_q    <= 1'b0;
      trap_q    <= 1'b0;
      trap_pc_q <= '0;
    end else begin
      pc_q    <= pc_next;
      valid_q <= valid_next;
      pred_q  <= pred_next;
      trap_q  <= trap_next;
      if (pc_id_load) begin
        pc_id_q <= pc_q;
      end
      if (trap_next) begin
        trap_pc_q <= redirect_target;
      end
    end
  end

  assign flush_fetch   = redirect | (state == HALT);
  assign PC            = pc_q;
  assign PC_ID         = pc_id_q;
  assign valid_ID      = valid_q;
  assign pred_taken_ID = pred_q;
  assign misalign_trap = trap_q;
  assign trap_pc       = trap_pc_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: a table of per-cycle vectors plus
// hand-written reset/boot/trap sequences, checked through a scoreboard queue.
module tb_fetch_pc_gen;

`ifdef FETCH_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  typedef struct {
    logic        hold;
    logic        redirect;
    logic [31:0] target;
    logic        btu;
    logic [31:0] btpc;
    logic [31:0] bttgt;
    logic        exp_flush;
    logic [31:0] exp_pc;
    logic [31:0] exp_pcid;
    logic        exp_valid;
    logic        exp_pred;
    logic        exp_trap;
    logic [31:0] exp_trap_pc;
  } vec_t;

  logic        Clock;
  logic        nReset;
  logic        hold;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        bt_update;
  logic [31:0] bt_pc;
  logic [31:0] bt_target;
  logic [31:0] PC;
  logic        flush_fetch;
  logic [31:0] PC_ID;
  logic        valid_ID;
  logic        pred_taken_ID;
  logic        misalign_trap;
  logic [31:0] trap_pc;

  vec_t  sb[$];
  vec_t  tbl[$];
  int    compared;
  int    mismatched;
  string tag;

  fetch_pc_gen dut (
    .Clock          (Clock),
    .nReset         (nReset),
    .hold           (hold),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .bt_update      (bt_update),
    .bt_pc          (bt_pc),
    .bt_target      (bt_target),
    .PC             (PC),
    .flush_fetch    (flush_fetch),
    .PC_ID          (PC_ID),
    .valid_ID       (valid_ID),
    .pred_taken_ID  (pred_taken_ID),
    .misalign_trap  (misalign_trap),
    .trap_pc        (trap_pc)
  );

  // 10-unit clock period.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic h, input logic r, input logic [31:0] t,
                              input logic bu, input logic [31:0] bp, input logic [31:0] bt,
                              input logic fl, input logic [31:0] pc, input logic [31:0] pcid,
                              input logic v, input logic pr, input logic tr, input logic [31:0] tp);
    vec_t x;
    x.hold = h; x.redirect = r; x.target = t;
    x.btu = bu; x.btpc = bp; x.bttgt = bt;
    x.exp_flush = fl; x.exp_pc = pc; x.exp_pcid = pcid;
    x.exp_valid = v; x.exp_pred = pr; x.exp_trap = tr; x.exp_trap_pc = tp;
    return x;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s %s: got 0x%08h expected 0x%08h", tag, name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational flush, queue the post-edge expectation.
  task automatic applyStimulus(input vec_t v);
    hold            = v.hold;
    redirect        = v.redirect;
    redirect_target = v.target;
    bt_update       = v.btu;
    bt_pc           = v.btpc;
    bt_target       = v.bttgt;
    #1;
    cmp("flush_fetch", {31'b0, flush_fetch}, {31'b0, v.exp_flush});
    sb.push_back(v);
  endtask

  // Wait for the active edge, then pop the oldest expectation and compare registered outputs.
  task automatic checkOutput();
    vec_t e;
    @(posedge Clock);
    #1;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s scoreboard: got empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      cmp("PC", PC, e.exp_pc);
      cmp("PC_ID", PC_ID, e.exp_pcid);
      cmp("valid_ID", {31'b0, valid_ID}, {31'b0, e.exp_valid});
      cmp("pred_taken_ID", {31'b0, pred_taken_ID}, {31'b0, e.exp_pred});
      cmp("misalign_trap", {31'b0, misalign_trap}, {31'b0, e.exp_trap});
      cmp("trap_pc", trap_pc, e.exp_trap_pc);
    end
  endtask

  // Assert reset away from any edge and check the asynchronously cleared state.
  task automatic assertReset(input string name);
    tag = name;
    hold = 1'b0; redirect = 1'b0; redirect_target = '0;
    bt_update = 1'b0; bt_pc = '0; bt_target = '0;
    #2;
    nReset = 1'b0;
    #1;
    cmp("PC", PC, 32'h0);
    cmp("PC_ID", PC_ID, 32'h0);
    cmp("valid_ID", {31'b0, valid_ID}, 32'h0);
    cmp("pred_taken_ID", {31'b0, pred_taken_ID}, 32'h0);
    cmp("misalign_trap", {31'b0, misalign_trap}, 32'h0);
    cmp("trap_pc", trap_pc, 32'h0);
    cmp("flush_fetch", {31'b0, flush_fetch}, 32'h0);
    @(negedge Clock);
    nReset = 1'b1;
  endtask

  initial begin
    logic [31:0] p16;
    logic [31:0] p17;
    logic [31:0] pid17;
    logic [31:0] halt_pc;
    compared   = 0;
    mismatched = 0;
    nReset     = 1'b1;

    // Addresses that depend on whether the BTB steers the fetch of 0x20 to 0x80.
    p16     = BTB ? 32'h80 : 32'h24;
    p17     = BTB ? 32'h84 : 32'h28;
    pid17   = BTB ? 32'h80 : 32'h24;
    halt_pc = p17;

    //         hold  redir target        btu  btpc   bttgt  flush pc      pcid    v     pred  trap  trap_pc
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,  0, 32'h04, 32'h00, 1, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,  0, 32'h08, 32'h04, 1, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,  0, 32'h0C, 32'h08, 1, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,  0, 32'h10, 32'h0C, 1, 0, 0, 32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,  32'h0,  0, 32'h10, 32'h0C, 0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,  32'h0,  0, 32'h10, 32'h0C, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,  0, 32'h14, 32'h10, 1, 0, 0, 32'h0));
    tbl.push_back(mk(1, 1, 32'h40,       0, 32'h0,  32'h0,  1, 32'h40, 32'h14, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,  0, 32'h44, 32'h40, 1, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 32'hF8,       0, 32'h0,  32'h0,  1, 32'hF8, 32'h44, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,  0, 32'hFC, 32'hF8, 1, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,  0, 32'h00, 32'hFC, 1, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 32'h0001_0020, 0, 32'h0, 32'h0,  1, 32'h20, 32'h00, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        1, 32'h20, 32'h80, 0, 32'h24, 32'h20, 1, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 32'h20,       0, 32'h0,  32'h0,  1, 32'h20, 32'h24, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,  0, p16,    32'h20, 1, BTB, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,  0, p17,    pid17,  1, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 32'h42,       0, 32'h0,  32'h0,  1, halt_pc, halt_pc, 0, 0, 1, 32'h42));
    tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,  32'h0,  1, halt_pc, halt_pc, 0, 0, 0, 32'h42));
    tbl.push_back(mk(0, 1, 32'h100,      0, 32'h0,  32'h0,  1, halt_pc, halt_pc, 0, 0, 0, 32'h42));
    tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,  32'h0,  1, halt_pc, halt_pc, 0, 0, 0, 32'h42));

    // Power-on reset, then release on a falling edge and drive the table back to back.
    @(negedge Clock);
    assertReset("reset");
    for (int i = 0; i < tbl.size(); i++) begin
      tag = $sformatf("step%0d", i);
      applyStimulus(tbl[i]);
      checkOutput();
      @(negedge Clock);
    end

    // Reset out of HALT, then a redirect on the very first (BOOT) edge is taken.
    assertReset("boot_redirect_reset");
    tag = "boot_redirect";
    applyStimulus(mk(0, 1, 32'h30, 0, 32'h0, 32'h0, 1, 32'h30, 32'h00, 0, 0, 0, 32'h0));
    checkOutput();
    @(negedge Clock);
    applyStimulus(mk(0, 0, 32'h0,  0, 32'h0, 32'h0, 0, 32'h34, 32'h30, 1, 0, 0, 32'h0));
    checkOutput();

    // A misaligned redirect in BOOT traps and parks the generator in HALT.
    @(negedge Clock);
    assertReset("boot_trap_reset");
    tag = "boot_trap";
    applyStimulus(mk(0, 1, 32'h31, 0, 32'h0, 32'h0, 1, 32'h00, 32'h00, 0, 0, 1, 32'h31));
    checkOutput();
    @(negedge Clock);
    applyStimulus(mk(0, 0, 32'h0,  0, 32'h0, 32'h0, 1, 32'h00, 32'h00, 0, 0, 0, 32'h31));
    checkOutput();
    @(negedge Clock);
    applyStimulus(mk(0, 0, 32'h0,  0, 32'h0, 32'h0, 1, 32'h00, 32'h00, 0, 0, 0, 32'h31));
    checkOutput();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
